psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- Consumer end of the tile output interface; takes the packed per-column accumulated partial sums from the 5x5 tile.
- Accumulates them across input-channel passes into wide registers.
- On the last pass, applies rounding right-shift, optional ReLU and signed saturation.
- Streams one quantized result per column to the output feature-map buffer over a valid/ready handshake, applying backpressure to the tile while draining.

Parameters:
- AK_BW, 20, width of each signed column partial sum from the tile
- COLS, 5, number of tile columns / result lanes
- ACC_BW, 32, width of each signed internal accumulator
- O_BW, 8, width of each signed output result

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_acc_valid  input  1  i_acc_pp carries a valid column vector this cycle
- o_acc_ready  output  1  collector accepts a vector this cycle
- i_acc_pp  input  AK_BW*COLS  packed signed partial sums, column 0 in LSBs
- i_first_pass  input  1  accepted vector starts a new accumulation (overwrite)
- i_last_pass  input  1  accepted vector completes accumulation; start drain
- i_shift  input  5  requant arithmetic right-shift amount, 0..31
- i_relu_en  input  1  clamp negative results to 0 before shift
- o_data  output  O_BW  signed quantized result
- o_col_idx  output  3  column index of o_data
- o_valid  output  1  o_data/o_col_idx valid
- i_ready  input  1  downstream accepts o_data
- o_done  output  1  one-cycle pulse after final column handshake
- o_err  output  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all acc=0, o_acc_ready=1, o_valid=0, o_data=0, o_col_idx=0, o_done=0, o_err=0.
- Accept: a transfer occurs when i_acc_valid && o_acc_ready. If i_acc_valid && !o_acc_ready, the vector is ignored and no state changes; the tile must hold it.
- States: IDLE (no partial data), ACCUM (partial sums held), DRAIN (outputting).
- IDLE + accept:
  - acc[c] = sext(i_acc_pp[c]).
  - If i_first_pass=0, o_err is set (sticky) and the vector is still loaded as first.
  - Next state is DRAIN if i_last_pass, else ACCUM.
- ACCUM + accept:
  - If i_first_pass: acc[c] = sext(in[c]). Otherwise acc[c] += sext(in[c]), wrapping mod 2^ACC_BW with no saturation.
  - Next state is DRAIN if i_last_pass, else ACCUM.
- first_pass && last_pass in the same transfer is a single-pass job: load, then go to DRAIN.
- o_acc_ready = 1 in IDLE/ACCUM, 0 in DRAIN.
- i_shift and i_relu_en are sampled on the accepting cycle that has i_last_pass=1, and held through the drain.
- DRAIN:
  - The cycle after the last-pass accept: o_valid=1, o_col_idx=0, o_data=q(acc[0]). Latency is 1 cycle from the accept edge.
  - o_data/o_col_idx are held stable while o_valid && !i_ready.
  - On handshake (o_valid && i_ready) with col<COLS-1: present col+1 next cycle, so back-to-back output is possible.
  - On handshake at col=COLS-1: next cycle o_valid=0, o_done=1 for one cycle, state=IDLE, o_acc_ready=1.
- Quantization q(x):
  1. v = (relu_en && x<0) ? 0 : x.
  2. If shift>0: v = (v + 2^(shift-1)) >>> shift (round half up, arithmetic), computed at ACC_BW+1 bits so there is no rounding overflow.
  3. Saturate to [-2^(O_BW-1), 2^(O_BW-1)-1].
- o_data is registered, with no combinational path from i_acc_pp.
- o_err is cleared only by reset.
- Reset mid-drain: everything returns to the reset values immediately and the partial drain is abandoned.

Test Plan:
- Reset: hold rst_n=0 mid-DRAIN -> o_valid=0, o_acc_ready=1, o_done=0, acc cleared; after release, a last-pass vector of 0s outputs 5 zeros.
- Single pass, first=last=1, cols {100,-100,127,128,-129}, shift=0, relu=0, i_ready=1 -> o_data 100,-100,127,127,-128 on 5 consecutive cycles, col_idx 0..4, then o_done pulse.
- Three passes of each column = 1000, shift=4, relu=0 -> acc=3000, (3000+8)>>>4=188 -> saturated 127 on all columns; with shift=6 -> (3000+32)>>>6=47.
- ReLU/rounding, single pass cols {-50,24,23,-1,8}, shift=4, relu=1 -> 0,2,1,0,1; with relu=0 -> -3,2,1,0,1.
- Backpressure: i_ready=0 for 3 cycles at col 2 -> o_data/o_col_idx stable, o_acc_ready=0; i_acc_valid pulses during drain are ignored and the next job starts fresh.
- Protocol error: in IDLE, accept with first_pass=0, value 7 -> o_err=1 sticky, acc=7; next job outputs correctly and o_err stays 1 until reset.

Source files
------------

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - accumulates tile column partial sums across passes and streams requantized results
module psum_collector #(
  parameter int AK_BW  = 20,
  parameter int COLS   = 5,
  parameter int ACC_BW = 32,
  parameter int O_BW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_acc_valid,
  output logic                  o_acc_ready,
  input  logic [AK_BW*COLS-1:0] i_acc_pp,
  input  logic                  i_first_pass,
  input  logic                  i_last_pass,
  input  logic [4:0]            i_shift,
  input  logic                  i_relu_en,
  output logic [O_BW-1:0]       o_data,
  output logic [2:0]            o_col_idx,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic signed [ACC_BW:0] SAT_MAX = {{(ACC_BW-O_BW+2){1'b0}}, {(O_BW-1){1'b1}}};
  localparam logic signed [ACC_BW:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nxt;

  logic signed [ACC_BW-1:0] acc     [COLS];
  logic signed [ACC_BW-1:0] acc_nxt [COLS];
  logic signed [ACC_BW-1:0] in_ext  [COLS];
  logic signed [ACC_BW-1:0] drain_sel;
  logic [4:0]               shift_r;
  logic                     relu_r;
  logic [2:0]               col;
  logic [2:0]               col_inc;
  logic                     accept;
  logic                     hs;
  logic                     last_col;
  logic                     load_new;
  logic [O_BW-1:0]          q_first;
  logic [O_BW-1:0]          q_next;

  // Rounding add is done one bit wider than the accumulator so it cannot overflow.
  function automatic logic [O_BW-1:0] quant(input logic signed [ACC_BW-1:0] x,
                                             input logic [4:0] sh,
                                             input logic relu);
    logic signed [ACC_BW:0] v;
    logic signed [ACC_BW:0] rnd;
    logic signed [ACC_BW:0] sum;
    v   = (relu && x < 0) ? '0 : {x[ACC_BW-1], x};
    rnd = (ACC_BW+1)'(({{ACC_BW{1'b0}}, 1'b1} << sh) >> 1);
    sum = (v + rnd) >>> sh;
    if (sum > SAT_MAX)
      return SAT_MAX[O_BW-1:0];
    else if (sum < SAT_MIN)
      return SAT_MIN[O_BW-1:0];
    else
      return sum[O_BW-1:0];
  endfunction

  assign accept    = i_acc_valid && o_acc_ready;
  assign hs        = o_valid && i_ready;
  assign last_col  = (col == 3'(COLS-1));
  assign col_inc   = col + 3'd1;
  assign load_new  = (state == IDLE) || i_first_pass;
  assign o_col_idx = col;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      in_ext[c]  = {{(ACC_BW-AK_BW){i_acc_pp[c*AK_BW+AK_BW-1]}}, i_acc_pp[c*AK_BW +: AK_BW]};
      acc_nxt[c] = load_new ? in_ext[c] : acc[c] + in_ext[c];
    end
  end

  always_comb begin
    drain_sel = acc[0];
    for (int c = 0; c < COLS; c++)
      if (3'(c) == col_inc) drain_sel = acc[c];
  end

  // Column 0 is quantized from the freshly accumulated value so it is ready the cycle after the last accept.
  assign q_first = quant(acc_nxt[0], i_shift, i_relu_en);
  assign q_next  = quant(drain_sel, shift_r, relu_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = i_last_pass ? DRAIN : ACCUM;
      DRAIN:       if (hs && last_col) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_acc_ready = (state != DRAIN);
    o_valid     = (state == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) acc[c] <= '0;
      shift_r <= '0;
      relu_r  <= 1'b0;
      col     <= '0;
      o_data  <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        for (int c = 0; c < COLS; c++) acc[c] <= acc_nxt[c];
        if (state == IDLE && !i_first_pass) o_err <= 1'b1;
        if (i_last_pass) begin
          shift_r <= i_shift;
          relu_r  <= i_relu_en;
          col     <= '0;
          o_data  <= q_first;
        end
      end
      if (hs) begin
        if (last_col) begin
          col    <= '0;
          o_done <= 1'b1;
        end else begin
          col    <= col_inc;
          o_data <= q_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - directed and randomized checks of psum_collector against an arithmetic reference model
module tb_psum_collector;

  localparam int AK_BW  = 20;
  localparam int COLS   = 5;
  localparam int ACC_BW = 32;
  localparam int O_BW   = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_acc_valid;
  logic                  o_acc_ready;
  logic [AK_BW*COLS-1:0] i_acc_pp;
  logic                  i_first_pass;
  logic                  i_last_pass;
  logic [4:0]            i_shift;
  logic                  i_relu_en;
  logic [O_BW-1:0]       o_data;
  logic [2:0]            o_col_idx;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_done;
  logic                  o_err;

  always #5 clk = ~clk;

  psum_collector #(.AK_BW(AK_BW), .COLS(COLS), .ACC_BW(ACC_BW), .O_BW(O_BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_acc_valid(i_acc_valid), .o_acc_ready(o_acc_ready), .i_acc_pp(i_acc_pp),
    .i_first_pass(i_first_pass), .i_last_pass(i_last_pass),
    .i_shift(i_shift), .i_relu_en(i_relu_en),
    .o_data(o_data), .o_col_idx(o_col_idx), .o_valid(o_valid), .i_ready(i_ready),
    .o_done(o_done), .o_err(o_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  int vec   [COLS];
  int m_acc [COLS];
  int m_exp [COLS];
  bit m_partial = 1'b0;
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requantization from the arithmetic definition: floor((v + 2^(s-1)) / 2^s), then clamp.
  function automatic int ref_q(input int x, input int sh, input bit relu);
    longint v, d, qv, lim;
    v = (relu && x < 0) ? 0 : x;
    if (sh > 0) begin
      d  = longint'(1) << sh;
      v  = v + d / 2;
      qv = v / d;
      if ((v % d) != 0 && v < 0) qv = qv - 1;
      v  = qv;
    end
    lim = longint'(1) << (O_BW - 1);
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
    return int'(v);
  endfunction

  function automatic int rnd_ak();
    return int'($urandom_range(0, (1 << AK_BW) - 1)) - (1 << (AK_BW - 1));
  endfunction

  task automatic send(input bit first, input bit last, input int sh, input bit relu);
    check("acc_ready_before_send", o_acc_ready, 1);
    i_acc_valid  = 1'b1;
    i_first_pass = first;
    i_last_pass  = last;
    i_shift      = 5'(sh);
    i_relu_en    = relu;
    for (int c = 0; c < COLS; c++) i_acc_pp[c*AK_BW +: AK_BW] = AK_BW'(vec[c]);
    for (int c = 0; c < COLS; c++) m_acc[c] = (!m_partial || first) ? vec[c] : m_acc[c] + vec[c];
    if (!m_partial && !first) m_err = 1'b1;
    m_partial = 1'b1;
    if (last) begin
      for (int c = 0; c < COLS; c++) m_exp[c] = ref_q(m_acc[c], sh, relu);
      m_partial = 1'b0;
    end
    @(negedge clk);
    i_acc_valid = 1'b0;
  endtask

  task automatic drain(input int stall_col, input int stall_n);
    for (int c = 0; c < COLS; c++) begin
      for (int w = 0; w < ((c == stall_col) ? stall_n : 0); w++) begin
        i_ready      = 1'b0;
        i_acc_valid  = 1'b1;
        i_first_pass = 1'b1;
        i_last_pass  = 1'b1;
        i_acc_pp     = (AK_BW*COLS)'({$urandom(), $urandom(), $urandom(), $urandom()});
        check("stall_valid", o_valid, 1);
        check("stall_col_idx", o_col_idx, c);
        check("stall_data", $signed(o_data), m_exp[c]);
        check("stall_acc_ready", o_acc_ready, 0);
        @(negedge clk);
      end
      i_acc_valid = 1'b0;
      i_ready     = 1'b1;
      check("drain_valid", o_valid, 1);
      check("drain_col_idx", o_col_idx, c);
      check("drain_data", $signed(o_data), m_exp[c]);
      check("drain_acc_ready", o_acc_ready, 0);
      @(negedge clk);
    end
    i_ready = 1'b0;
    check("end_valid", o_valid, 0);
    check("end_done", o_done, 1);
    check("end_acc_ready", o_acc_ready, 1);
    check("end_err", o_err, m_err);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_acc_ready"}, o_acc_ready, 1);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_col_idx"}, o_col_idx, 0);
  endtask

  task automatic random_job();
    int passes;
    passes = $urandom_range(1, 4);
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c < COLS; c++) vec[c] = rnd_ak();
      send((p == 0) || ($urandom_range(0, 5) == 0), p == passes - 1,
           $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end
    drain($urandom_range(0, COLS - 1), $urandom_range(0, 2));
  endtask

  initial begin
    i_acc_valid  = 1'b0;
    i_acc_pp     = '0;
    i_first_pass = 1'b0;
    i_last_pass  = 1'b0;
    i_shift      = '0;
    i_relu_en    = 1'b0;
    i_ready      = 1'b0;
    #1;
    reset_check("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vec = '{100, -100, 127, 128, -129};
    send(1, 1, 0, 0);
    drain(-1, 0);

    vec = '{1000, 1000, 1000, 1000, 1000};
    send(1, 0, 4, 0);
    send(0, 0, 4, 0);
    send(0, 1, 4, 0);
    drain(-1, 0);
    send(1, 0, 0, 1);
    send(0, 0, 0, 1);
    send(0, 1, 6, 0);
    drain(-1, 0);

    vec = '{-50, 24, 23, -1, 8};
    send(1, 1, 4, 1);
    drain(-1, 0);
    send(1, 1, 4, 0);
    drain(-1, 0);

    for (int c = 0; c < COLS; c++) vec[c] = rnd_ak();
    send(1, 1, 3, 0);
    drain(2, 3);

    for (int j = 0; j < 10; j++) random_job();

    for (int c = 0; c < COLS; c++) vec[c] = rnd_ak();
    send(1, 1, 0, 0);
    i_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_check("mid_drain_reset");
    m_partial = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec = '{0, 0, 0, 0, 0};
    send(1, 1, 0, 0);
    drain(-1, 0);

    vec = '{7, 7, 7, 7, 7};
    send(0, 1, 0, 0);
    check("err_set", o_err, 1);
    drain(-1, 0);
    random_job();
    random_job();
    check("err_sticky", o_err, 1);

    rst_n = 1'b0;
    #1;
    reset_check("final_reset");
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
